// File: rtl/cas_lock_pkg.sv
// Shared types and helpers for the clocked CAS-Lock output-flip unit.
package cas_lock_pkg;

  // Widest chain the cascade helper evaluates; N_IN must not exceed it.
  localparam int MAX_W = 64;

  // Reference counter width for the default 32-bit key halves.
  localparam int DEF_N_IN  = 32;
  localparam int DEF_CNT_W = $clog2(2 * DEF_N_IN) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ARMED} key_state_t;

  // Beat counter width for a given key-half width.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n) + 1;
  endfunction

  // AND/OR cascade: g0 = x0, gi = g(i-1) OP_i xi, OP_i = OR when mask bit i set.
  function automatic logic cas_chain(input logic [MAX_W-1:0] x,
                                     input logic [MAX_W-1:0] chain_mask,
                                     input int               n);
    logic g;
    g = x[0];
    for (int i = 1; i < MAX_W; i++) begin
      if (i < n) g = chain_mask[i] ? (g | x[i]) : (g & x[i]);
    end
    return g;
  endfunction

endpackage

// File: rtl/cas_key_loader.sv
// Serial key loader: shifts 2*N_IN beats into a shadow register and
// commits them atomically to the active key after the last beat.
module cas_key_loader
  import cas_lock_pkg::*;
#(
  parameter int N_IN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_valid,
  input  logic            key_bit,
  input  logic            key_abort,
  output logic            key_ready,
  output logic            key_loaded,
  output logic [N_IN-1:0] key_a,
  output logic [N_IN-1:0] key_b
);

  localparam int CW = cnt_width(N_IN);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CW-1:0] LAST = CW'(2 * N_IN - 1);

  key_state_t      state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [N_IN-1:0] sh_a, sh_b;
  logic            wr;
  logic            in_b;
  logic [IW-1:0]   idx;

  // Only the commit cycle stalls the serial port.
  assign key_ready = (state != COMMIT);

  // Beats 0..N_IN-1 land in half A, the rest in half B.
  assign in_b = (cnt >= CW'(N_IN));
  assign idx  = IW'(in_b ? (cnt - CW'(N_IN)) : cnt);

  // Next-state and beat-accept decode; abort wins over a same-cycle beat.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wr      = 1'b0;
    case (state)
      IDLE, ARMED: begin
        if (key_valid) begin
          wr      = 1'b1;
          cnt_d   = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (key_abort) begin
          cnt_d   = '0;
          state_d = key_loaded ? ARMED : IDLE;
        end else if (key_valid) begin
          wr = 1'b1;
          if (cnt == LAST) begin
            cnt_d   = '0;
            state_d = COMMIT;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      COMMIT:  state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, shadow capture and atomic commit to the active key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sh_a       <= '0;
      sh_b       <= '0;
      key_a      <= '0;
      key_b      <= '0;
      key_loaded <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (wr && !in_b) sh_a[idx] <= key_bit;
      if (wr &&  in_b) sh_b[idx] <= key_bit;
      if (state == COMMIT) begin
        key_a      <= sh_a;
        key_b      <= sh_b;
        key_loaded <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cas_lock_seq_unit.sv
// Clocked CAS-Lock output flip: 2-stage pipeline evaluating the two key
// chains and XORing CASOP into the host netlist outputs.
module cas_lock_seq_unit
  import cas_lock_pkg::*;
#(
  parameter int               N_IN       = 32,
  parameter logic [N_IN-1:0]  CHAIN_MASK = '0,
  parameter logic [N_IN-1:0]  INV_A      = '0,
  parameter logic [N_IN-1:0]  INV_B      = '0,
  parameter int               N_OUT      = 1,
  parameter logic [N_OUT-1:0] FLIP_MASK  = N_OUT'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             key_bit,
  input  logic             key_abort,
  output logic             key_loaded,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_data,
  input  logic [N_OUT-1:0] func_in,
  output logic             out_valid,
  output logic [N_OUT-1:0] out_data,
  output logic             casop
);

  localparam int STAGES = 2;

  logic [N_IN-1:0]   key_a, key_b;
  logic [N_IN-1:0]   xa_q, xb_q;
  logic [N_OUT-1:0]  func_q;
  logic [STAGES:1]   vld_pipe;
  logic              chain_a, chain_b, casop_c;

  cas_key_loader #(.N_IN(N_IN)) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_bit    (key_bit),
    .key_abort  (key_abort),
    .key_ready  (key_ready),
    .key_loaded (key_loaded),
    .key_a      (key_a),
    .key_b      (key_b)
  );

  // Cascade is evaluated on the registered XOR terms between the stages.
  assign chain_a = cas_chain(MAX_W'(xa_q), MAX_W'(CHAIN_MASK), N_IN);
  assign chain_b = cas_chain(MAX_W'(xb_q), MAX_W'(CHAIN_MASK), N_IN);
  assign casop_c = chain_a & ~chain_b;

  assign out_valid = vld_pipe[STAGES];

  // Valid bits always shift; data registers only load on valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      xa_q     <= '0;
      xb_q     <= '0;
      func_q   <= '0;
      out_data <= '0;
      casop    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) begin
        xa_q   <= key_a ^ in_data ^ INV_A;
        xb_q   <= key_b ^ in_data ^ INV_B;
        func_q <= func_in;
      end
      if (vld_pipe[1]) begin
        out_data <= func_q ^ (FLIP_MASK & {N_OUT{casop_c}});
        casop    <= casop_c;
      end
    end
  end

endmodule
